// File: rtl/shifter_pkg.sv
// Shared types for the multi-cycle shift unit: shift operation codes
// and the sequencer state encoding.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL  = 2'b00,
        SRL  = 2'b01,
        SRA  = 2'b10,
        RSVD = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shifter_stage.sv
// One power-of-two shifter stage: shifts i_data by 2^i_k when i_en is set.
// Each candidate stage is generated, then a mux chain keyed on i_k picks one.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned SHAMT_W = $clog2(N)
) (
    input  logic [N-1:0]       i_data,
    input  logic               i_en,
    input  logic [SHAMT_W-1:0] i_k,
    input  shift_op_t          i_op,
    input  logic               i_sign,
    output logic [N-1:0]       o_data
);

    logic         w_fill;
    logic [N-1:0] w_chain [SHAMT_W+1];

    assign w_fill     = (i_op == SRA) ? i_sign : 1'b0;
    assign w_chain[0] = i_data;

    for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
        localparam int unsigned S = 1 << j;
        logic [N-1:0] w_sll;
        logic [N-1:0] w_sr;
        logic [N-1:0] w_cand;

        assign w_sll  = {i_data[N-1-S:0], {S{1'b0}}};
        assign w_sr   = {{S{w_fill}}, i_data[N-1:S]};
        assign w_cand = (i_op == SLL)  ? w_sll  :
                        (i_op == RSVD) ? i_data : w_sr;
        assign w_chain[j+1] = (i_k == SHAMT_W'(j)) ? w_cand : w_chain[j];
    end

    assign o_data = i_en ? w_chain[SHAMT_W] : i_data;

endmodule

// File: rtl/shifter_sequencer.sv
// Multi-cycle shift controller: accepts one request, walks the single
// shifter_stage through SHAMT_W power-of-two stages, then holds the result.
module shifter_sequencer
    import shifter_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned SHAMT_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [N-1:0]       i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [1:0]         i_op,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [N-1:0]       o_data,
    output logic               busy
);

    seq_state_t         r_state;
    logic [SHAMT_W-1:0] r_k;
    logic [N-1:0]       r_work;
    logic [SHAMT_W-1:0] r_shamt;
    shift_op_t          r_op;
    logic               r_sign;
    logic               r_o_valid;
    logic [N-1:0]       r_o_data;
    logic               r_busy;

    logic               w_en;
    logic               w_last;
    logic [N-1:0]       w_next;

    // Stage k is enabled by shamt bit k; a one-hot mask avoids a variable bit-select.
    assign w_en   = |(r_shamt & (SHAMT_W'(1) << r_k));
    assign w_last = (r_k == SHAMT_W'(SHAMT_W - 1));

    shifter_stage #(
        .N       (N),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .i_data (r_work),
        .i_en   (w_en),
        .i_k    (r_k),
        .i_op   (r_op),
        .i_sign (r_sign),
        .o_data (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_work    <= '0;
            r_shamt   <= '0;
            r_op      <= SLL;
            r_sign    <= 1'b0;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_work  <= i_data;
                        r_shamt <= i_shamt;
                        r_op    <= shift_op_t'(i_op);
                        r_sign  <= i_data[N-1];
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_next;
                    r_k    <= r_k + 1'b1;
                    if (w_last) begin
                        r_o_valid <= 1'b1;
                        r_o_data  <= w_next;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        r_o_valid <= 1'b0;
                        r_o_data  <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_k       <= '0;
                    r_o_valid <= 1'b0;
                    r_o_data  <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign i_ready = (r_state == IDLE);
    assign o_valid = r_o_valid;
    assign o_data  = r_o_data;
    assign busy    = r_busy;

endmodule
